sd_cmd_sequencer: RTL

Sequences the SD bit timer (`timerSD`) to emit one complete 48-bit SD command frame on the CMD line. Before the first command it runs the mandatory power-up idle phase: at least 74 SDCLK cycles with CMD held high. The block drives the timer's `enable`, `speed` and `clear_byte` inputs. It consumes the timer's `shift_enable` and `byte_received`, serializes the frame and generates CRC7. It sits between the host-side command logic and the timer/SD pad.

---
 rtl/sd_pkg.sv | 27 ++
 rtl/sd_crc7.sv | 24 ++
 rtl/timerSD.sv | 49 ++++
 rtl/sd_cmd_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command path: sequencer states, CRC7
// polynomial, frame length and timer speed encodings.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_LOAD,
    ST_INIT_RUN,
    ST_CMD_LOAD,
    ST_CMD_RUN,
    ST_FINISH
  } sd_seq_state_t;

  localparam logic [6:0] SD_CRC7_POLY  = 7'h09;
  localparam int         SD_FRAME_BITS = 48;
  localparam int         SD_CRC_FIRST  = 40;

  localparam logic [1:0] SD_SPD_SLOW = 2'b00;
  localparam logic [1:0] SD_SPD_FAST = 2'b01;
  localparam logic [1:0] SD_SPD_MID  = 2'b10;

  // The unused encoding 2'b11 falls back to the slow bit rate.
  function automatic logic [1:0] sd_map_speed(input logic [1:0] sel);
    return (sel == 2'b11) ? SD_SPD_SLOW : sel;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one message bit absorbed per enabled cycle.
module sd_crc7 import sd_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = din ^ crc[6];

  // LFSR update: shift left and fold the polynomial in when the feedback bit is set.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? SD_CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/timerSD.sv
// SD bit timer: one shift_enable pulse per bit period and a byte_received
// pulse together with every eighth shift_enable.
module timerSD import sd_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       clear_byte,
  output logic       shift_enable,
  output logic       byte_received
);

  logic [2:0] div_cnt;
  logic [2:0] div_last;
  logic [2:0] bit_idx;

  // Clock cycles per bit period, minus one, for the selected speed.
  always_comb begin
    case (speed)
      SD_SPD_FAST: div_last = 3'd1;
      SD_SPD_MID:  div_last = 3'd3;
      default:     div_last = 3'd7;
    endcase
  end

  // Divider and bit-in-byte counter; both pulses are registered one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst || clear_byte) begin
      div_cnt       <= '0;
      bit_idx       <= '0;
      shift_enable  <= 1'b0;
      byte_received <= 1'b0;
    end else begin
      shift_enable  <= 1'b0;
      byte_received <= 1'b0;
      if (enable) begin
        if (div_cnt == div_last) begin
          div_cnt       <= '0;
          shift_enable  <= 1'b1;
          bit_idx       <= bit_idx + 3'd1;
          byte_received <= (bit_idx == 3'd7);
        end else begin
          div_cnt <= div_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Drives the SD bit timer to send the power-up idle run and 48-bit command
// frames (start, direction, index, argument, CRC7, end bit) on CMD.
module sd_cmd_sequencer import sd_pkg::*; #(
  parameter int INIT_BYTES  = 10,
  parameter int FRAME_BYTES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  speed_sel,
  input  logic        shift_enable,
  input  logic        byte_received,
  output logic        tmr_enable,
  output logic [1:0]  tmr_speed,
  output logic        tmr_clear_byte,
  output logic        cmd_out,
  output logic        busy,
  output logic        done,
  output logic        init_done,
  output logic        protocol_err
);

  localparam logic [7:0] INIT_LAST  = 8'(INIT_BYTES);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_BYTES);
  localparam logic [5:0] CRC_FIRST  = 6'(SD_CRC_FIRST);
  localparam logic [5:0] END_BIT    = 6'(SD_FRAME_BITS - 1);

  sd_seq_state_t state, state_n;

  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  byte_cnt, byte_cnt_n;
  logic [39:0] payload;
  logic        accept_init, accept_cmd, misaligned, finish_init;
  logic [6:0]  crc;
  logic        crc_clear, crc_en;
  logic        cur_bit, cmd_out_n;
  logic [5:0]  payload_idx;
  logic [2:0]  crc_idx;

  assign crc_clear = (state == ST_CMD_LOAD);
  assign crc_en    = (state == ST_CMD_RUN) && shift_enable && (bit_cnt < CRC_FIRST);

  sd_crc7 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (cur_bit),
    .crc   (crc)
  );

  // Frame bit at the current bit position: payload, then CRC7 MSB first, then the end bit.
  always_comb begin
    payload_idx = 6'd39 - bit_cnt;
    crc_idx     = 3'(6'd46 - bit_cnt);
    if (bit_cnt < CRC_FIRST) begin
      cur_bit = payload[payload_idx];
    end else if (bit_cnt < END_BIT) begin
      cur_bit = crc[crc_idx];
    end else begin
      cur_bit = 1'b1;
    end
  end

  // Next-state and counter logic; a byte strobe must land on a byte boundary of bit_cnt.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    byte_cnt_n  = byte_cnt;
    accept_init = 1'b0;
    accept_cmd  = 1'b0;
    misaligned  = 1'b0;
    finish_init = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_req) begin
          state_n     = ST_INIT_LOAD;
          accept_init = 1'b1;
        end else if (cmd_start && init_done) begin
          state_n    = ST_CMD_LOAD;
          accept_cmd = 1'b1;
        end
      end
      ST_INIT_LOAD: begin
        byte_cnt_n = '0;
        state_n    = ST_INIT_RUN;
      end
      ST_INIT_RUN: begin
        if (byte_received) begin
          byte_cnt_n = byte_cnt + 8'd1;
          if (byte_cnt_n == INIT_LAST) begin
            state_n     = ST_FINISH;
            finish_init = 1'b1;
          end
        end
      end
      ST_CMD_LOAD: begin
        bit_cnt_n  = '0;
        byte_cnt_n = '0;
        state_n    = ST_CMD_RUN;
      end
      ST_CMD_RUN: begin
        if (shift_enable) begin
          bit_cnt_n = bit_cnt + 6'd1;
        end
        if (byte_received) begin
          if (bit_cnt_n[2:0] != 3'd0) begin
            misaligned = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            byte_cnt_n = byte_cnt + 8'd1;
            if (byte_cnt_n == FRAME_LAST) begin
              state_n = ST_FINISH;
            end
          end
        end
      end
      ST_FINISH: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // CMD idles high; the start bit goes out on entry to CMD_RUN and each
  // later bit follows one cycle after bit_cnt advances, so the CRC register
  // has already absorbed bit 39 when bit 40 is presented.
  always_comb begin
    cmd_out_n = 1'b1;
    if (state_n == ST_CMD_RUN) begin
      cmd_out_n = (state == ST_CMD_RUN) ? cur_bit : 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Counters and the request fields captured on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      payload  <= '0;
    end else begin
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      if (accept_cmd) begin
        payload <= {1'b0, 1'b1, cmd_index, cmd_arg};
      end
    end
  end

  // Registered outputs decoded from the next state, plus the sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_enable     <= 1'b0;
      tmr_speed      <= SD_SPD_SLOW;
      tmr_clear_byte <= 1'b0;
      cmd_out        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      init_done      <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      if (accept_init) begin
        tmr_speed <= SD_SPD_SLOW;
      end else if (accept_cmd) begin
        tmr_speed <= sd_map_speed(speed_sel);
      end
      tmr_enable     <= (state_n == ST_INIT_RUN) || (state_n == ST_CMD_RUN);
      tmr_clear_byte <= (state_n == ST_INIT_LOAD) || (state_n == ST_CMD_LOAD);
      cmd_out        <= cmd_out_n;
      busy           <= (state_n != ST_IDLE);
      done           <= (state_n == ST_FINISH);
      if (finish_init) begin
        init_done <= 1'b1;
      end
      if (misaligned) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule
